// File: rtl/riscv_core_btb_assoc.sv
// -----------------------------------------------------------------------------
// riscv_core_btb_assoc
//   Set-associative branch target buffer for the instruction-fetch stage.
//   Each entry holds a tag, a target, a 2-bit saturating direction counter and
//   an unconditional-jump flag. The fetch-PC lookup is combinational. Training
//   from EX and the whole-table flush are written at the next rising edge, so a
//   lookup in the same cycle as a write still sees the old contents.
//   A write that misses allocates the lowest-numbered invalid way. If every way
//   is valid, a per-set round-robin pointer names the victim and then advances.
//
// Ports
//   i_clk, i_rst_n               clock (rising edge), async active-low reset
//   i_flush                      invalidate all entries at the next edge
//   i_if_pc                      fetch PC to look up
//   o_branch_valid/_taken        lookup hit / predicted taken
//   o_branch_target, o_is_jump   predicted target / hit entry is a jump
//   i_ex_pc                      PC of the resolving instruction
//   i_update_branch_target       resolved target
//   i_valid_branch_update        conditional branch resolved this cycle
//   i_valid_branch_taken_update  resolved direction (qualified by the strobe)
//   i_jump                       unconditional jump resolved this cycle
// -----------------------------------------------------------------------------

// Hit-uniqueness checker: more than one matching way in a set is a design error.
module riscv_core_btb_assoc_chk #(
    parameter int WAYS = 2
) (
    input logic            i_clk,
    input logic            i_rst_n,
    input logic [WAYS-1:0] i_if_hit_vec,
    input logic [WAYS-1:0] i_ex_hit_vec
);

    // Flag any cycle where a lookup matches more than one way.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert ($countones(i_if_hit_vec) <= 1);
            assert ($countones(i_ex_hit_vec) <= 1);
        end
    end

endmodule

module riscv_core_btb_assoc #(
    parameter int PC_LEN   = 64,
    parameter int IDX_BITS = 8,
    parameter int WAYS     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [PC_LEN-1:0] i_if_pc,
    output logic              o_branch_valid,
    output logic              o_branch_taken,
    output logic [PC_LEN-1:0] o_branch_target,
    output logic              o_is_jump,
    input  logic [PC_LEN-1:0] i_ex_pc,
    input  logic [PC_LEN-1:0] i_update_branch_target,
    input  logic              i_valid_branch_update,
    input  logic              i_valid_branch_taken_update,
    input  logic              i_jump
);

    localparam int SETS  = 1 << IDX_BITS;
    localparam int TAG_W = PC_LEN - IDX_BITS - 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Saturating counter step toward strongly taken.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Saturating counter step toward strongly not-taken.
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Table storage (flopped, fully reset).
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   jump_q   [SETS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
    logic [PC_LEN-1:0] target_q [SETS][WAYS];
    logic [1:0]        ctr_q    [SETS][WAYS];

    logic [IDX_BITS-1:0] if_idx_s;
    logic [TAG_W-1:0]    if_tag_s;
    logic [IDX_BITS-1:0] ex_idx_s;
    logic [TAG_W-1:0]    ex_tag_s;
    logic [WAYS-1:0]     if_hit_vec_s;
    logic [WAYS-1:0]     ex_hit_vec_s;
    logic                ex_hit_s;
    logic [WAY_W-1:0]    ex_hit_way_s;
    logic [WAY_W-1:0]    free_way_s;
    logic [WAY_W-1:0]    alloc_way_s;
    logic [WAY_W-1:0]    rr_cur_s;
    logic                all_valid_s;
    logic [1:0]          ex_ctr_s;

    logic                wr_en_s;
    logic [WAY_W-1:0]    wr_way_s;
    logic [1:0]          wr_ctr_s;
    logic                wr_jump_s;
    logic                rr_adv_s;

    // Bit 0 of a PC never selects a set or forms part of a tag.
    logic unused_pc_lsb_s;
    assign unused_pc_lsb_s = i_if_pc[0] ^ i_ex_pc[0];

    assign if_idx_s = i_if_pc[IDX_BITS:1];
    assign if_tag_s = i_if_pc[PC_LEN-1:IDX_BITS+1];
    assign ex_idx_s = i_ex_pc[IDX_BITS:1];
    assign ex_tag_s = i_ex_pc[PC_LEN-1:IDX_BITS+1];

    // Fetch lookup. Hits are unique, so OR-combining the ways acts as a mux
    // and leaves every output at zero on a miss.
    always_comb begin
        if_hit_vec_s    = '0;
        o_branch_valid  = 1'b0;
        o_branch_taken  = 1'b0;
        o_branch_target = '0;
        o_is_jump       = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[if_idx_s][w] && (tag_q[if_idx_s][w] == if_tag_s)) begin
                if_hit_vec_s[w] = 1'b1;
                o_branch_valid  = 1'b1;
                o_branch_target = o_branch_target | target_q[if_idx_s][w];
                o_is_jump       = o_is_jump | jump_q[if_idx_s][w];
                o_branch_taken  = o_branch_taken | ctr_q[if_idx_s][w][1] | jump_q[if_idx_s][w];
            end else begin
                if_hit_vec_s[w] = 1'b0;
            end
        end
    end

    // EX-side tag match and allocation choice. The downward scan leaves the
    // lowest-numbered invalid way in free_way_s.
    always_comb begin
        ex_hit_vec_s = '0;
        ex_hit_s     = 1'b0;
        ex_hit_way_s = '0;
        free_way_s   = '0;
        all_valid_s  = &valid_q[ex_idx_s];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[ex_idx_s][w] && (tag_q[ex_idx_s][w] == ex_tag_s)) begin
                ex_hit_vec_s[w] = 1'b1;
                ex_hit_s        = 1'b1;
                ex_hit_way_s    = WAY_W'(w);
            end else begin
                ex_hit_vec_s[w] = 1'b0;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[ex_idx_s][w]) begin
                free_way_s = WAY_W'(w);
            end else begin
                free_way_s = free_way_s;
            end
        end
        alloc_way_s = all_valid_s ? rr_cur_s : free_way_s;
        ex_ctr_s    = ctr_q[ex_idx_s][ex_hit_way_s];
    end

    // Write request. Flush outranks the branch update, which outranks a jump.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_way_s  = '0;
        wr_ctr_s  = 2'b00;
        wr_jump_s = 1'b0;
        rr_adv_s  = 1'b0;
        if (i_flush) begin
            wr_en_s = 1'b0;
        end else if (i_valid_branch_update) begin
            wr_en_s   = 1'b1;
            wr_jump_s = 1'b0;
            if (ex_hit_s) begin
                wr_way_s = ex_hit_way_s;
                wr_ctr_s = i_valid_branch_taken_update ? ctr_inc(ex_ctr_s) : ctr_dec(ex_ctr_s);
            end else begin
                wr_way_s = alloc_way_s;
                wr_ctr_s = i_valid_branch_taken_update ? 2'b10 : 2'b01;
                rr_adv_s = all_valid_s;
            end
        end else if (i_jump) begin
            wr_en_s   = 1'b1;
            wr_ctr_s  = 2'b11;
            wr_jump_s = 1'b1;
            wr_way_s  = ex_hit_s ? ex_hit_way_s : alloc_way_s;
            rr_adv_s  = !ex_hit_s && all_valid_s;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table state: reset, whole-table invalidate, or a single-way write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                jump_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= 2'b00;
                end
            end
        end else if (i_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (wr_en_s) begin
            valid_q[ex_idx_s][wr_way_s]  <= 1'b1;
            jump_q[ex_idx_s][wr_way_s]   <= wr_jump_s;
            tag_q[ex_idx_s][wr_way_s]    <= ex_tag_s;
            target_q[ex_idx_s][wr_way_s] <= i_update_branch_target;
            ctr_q[ex_idx_s][wr_way_s]    <= wr_ctr_s;
        end
    end

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] rr_q [SETS];

        // Round-robin victim pointers; advance only when a full set is evicted.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_q[s] <= '0;
                end
            end else if (i_flush) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_q[s] <= '0;
                end
            end else if (rr_adv_s) begin
                rr_q[ex_idx_s] <= rr_q[ex_idx_s] + 1'b1;
            end
        end

        assign rr_cur_s = rr_q[ex_idx_s];
    end else begin : g_no_rr
        logic unused_rr_adv_s;
        assign unused_rr_adv_s = rr_adv_s;
        assign rr_cur_s        = '0;
    end

    riscv_core_btb_assoc_chk #(
        .WAYS (WAYS)
    ) u_chk (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_hit_vec (if_hit_vec_s),
        .i_ex_hit_vec (ex_hit_vec_s)
    );

endmodule

// File: tb/tb_riscv_core_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_riscv_core_btb_assoc
//   Directed bench for the set-associative BTB (PC_LEN=64, IDX_BITS=8, WAYS=2).
//   Expected lookup results are queued when a lookup is driven and popped and
//   compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_riscv_core_btb_assoc;

    localparam int PC_LEN = 64;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [PC_LEN-1:0] if_pc;
    logic              br_valid;
    logic              br_taken;
    logic [PC_LEN-1:0] br_target;
    logic              is_jump;
    logic [PC_LEN-1:0] ex_pc;
    logic [PC_LEN-1:0] upd_target;
    logic              upd_valid;
    logic              upd_taken;
    logic              jump;

    typedef struct {
        string             name;
        logic              v;
        logic              t;
        logic [PC_LEN-1:0] tgt;
        logic              j;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    riscv_core_btb_assoc #(
        .PC_LEN   (64),
        .IDX_BITS (8),
        .WAYS     (2)
    ) dut (
        .i_clk                       (clk),
        .i_rst_n                     (rst_n),
        .i_flush                     (flush),
        .i_if_pc                     (if_pc),
        .o_branch_valid              (br_valid),
        .o_branch_taken              (br_taken),
        .o_branch_target             (br_target),
        .o_is_jump                   (is_jump),
        .i_ex_pc                     (ex_pc),
        .i_update_branch_target      (upd_target),
        .i_valid_branch_update       (upd_valid),
        .i_valid_branch_taken_update (upd_taken),
        .i_jump                      (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Compare the oldest queued expectation against the live outputs.
    task automatic pop_check();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (br_valid === e.v) else begin
                failures++;
                $error("FAIL %s.valid observed=%0b expected=%0b", e.name, br_valid, e.v);
            end
            checks++;
            assert (br_taken === e.t) else begin
                failures++;
                $error("FAIL %s.taken observed=%0b expected=%0b", e.name, br_taken, e.t);
            end
            checks++;
            assert (br_target === e.tgt) else begin
                failures++;
                $error("FAIL %s.target observed=%0h expected=%0h", e.name, br_target, e.tgt);
            end
            checks++;
            assert (is_jump === e.j) else begin
                failures++;
                $error("FAIL %s.is_jump observed=%0b expected=%0b", e.name, is_jump, e.j);
            end
        end
    endtask

    task automatic clear_strobes();
        flush     = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        jump      = 1'b0;
    endtask

    // One cycle: look up pc with whatever update strobes are already set,
    // check at the falling edge, then let the rising edge commit the writes.
    task automatic look(input string name, input logic [PC_LEN-1:0] pc,
                        input logic v, input logic t,
                        input logic [PC_LEN-1:0] tgt, input logic j);
        exp_t e;
        e.name = name; e.v = v; e.t = t; e.tgt = tgt; e.j = j;
        if_pc = pc;
        exp_q.push_back(e);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic set_br(input logic [PC_LEN-1:0] pc, input logic tk, input logic [PC_LEN-1:0] tgt);
        ex_pc      = pc;
        upd_target = tgt;
        upd_valid  = 1'b1;
        upd_taken  = tk;
    endtask

    task automatic br(input logic [PC_LEN-1:0] pc, input logic tk, input logic [PC_LEN-1:0] tgt);
        set_br(pc, tk, tgt);
        tick();
    endtask

    task automatic jmp(input logic [PC_LEN-1:0] pc, input logic [PC_LEN-1:0] tgt);
        ex_pc      = pc;
        upd_target = tgt;
        jump       = 1'b1;
        tick();
    endtask

    localparam logic [PC_LEN-1:0] Z = 64'h0;

    initial begin
        rst_n = 1'b0;
        if_pc = 64'h0;
        ex_pc = 64'h0;
        upd_target = 64'h0;
        clear_strobes();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        look("reset_1000", 64'h1000, 1'b0, 1'b0, Z, 1'b0);

        // First allocation (weak taken), then one not-taken step
        br(64'h1000, 1'b1, 64'h2000);
        look("alloc_1000", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0);
        br(64'h1000, 1'b0, 64'h2000);
        look("nt_to_01", 64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0);

        // Saturation at 11: 01 -> 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 4; i++) br(64'h1000, 1'b1, 64'h2000);
        look("sat_11", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0);
        br(64'h1000, 1'b0, 64'h2000);
        look("11_to_10", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0);
        br(64'h1000, 1'b0, 64'h2000);
        look("10_to_01", 64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0);
        // Saturation at 00: four more not-taken, then two taken -> 01, 10
        for (int i = 0; i < 4; i++) br(64'h1000, 1'b0, 64'h2000);
        br(64'h1000, 1'b1, 64'h2000);
        look("00_to_01", 64'h1000, 1'b1, 1'b0, 64'h2000, 1'b0);
        br(64'h1000, 1'b1, 64'h2000);
        look("01_to_10", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0);

        // Replacement: 0x1200 fills way1, 0x1400 evicts way0 (rr 0 -> 1)
        br(64'h1200, 1'b1, 64'h2200);
        br(64'h1400, 1'b1, 64'h2400);
        look("evicted_1000", 64'h1000, 1'b0, 1'b0, Z, 1'b0);
        look("hit_1200", 64'h1200, 1'b1, 1'b1, 64'h2200, 1'b0);
        look("hit_1400", 64'h1400, 1'b1, 1'b1, 64'h2400, 1'b0);

        // Jump overwrites the hit way
        jmp(64'h1200, 64'h3000);
        look("jump_1200", 64'h1200, 1'b1, 1'b1, 64'h3000, 1'b1);

        // Branch update beats a same-cycle jump; same-cycle lookup sees old data
        set_br(64'h1400, 1'b0, 64'h5000);
        jump = 1'b1;
        look("nobypass_1400", 64'h1400, 1'b1, 1'b1, 64'h2400, 1'b0);
        look("prio_1400", 64'h1400, 1'b1, 1'b0, 64'h5000, 1'b0);

        // rr=1 now: 0x1600 evicts way1 (0x1200), rr -> 0
        br(64'h1600, 1'b1, 64'h2600);
        look("evicted_1200", 64'h1200, 1'b0, 1'b0, Z, 1'b0);
        look("hit_1600", 64'h1600, 1'b1, 1'b1, 64'h2600, 1'b0);
        look("keep_1400", 64'h1400, 1'b1, 1'b0, 64'h5000, 1'b0);

        // Jump miss allocates in another set (set 1, tag 8)
        jmp(64'h1002, 64'h4000);
        look("jalloc_1002", 64'h1002, 1'b1, 1'b1, 64'h4000, 1'b1);

        // 0x1800 evicts way0 (0x1400), rr -> 1 before the flush
        br(64'h1800, 1'b1, 64'h2800);
        look("hit_1800", 64'h1800, 1'b1, 1'b1, 64'h2800, 1'b0);

        // Flush with a same-cycle update: lookup still hits, nothing written
        flush = 1'b1;
        set_br(64'h1A00, 1'b1, 64'h2A00);
        look("flush_cycle", 64'h1600, 1'b1, 1'b1, 64'h2600, 1'b0);
        look("flushed_1600", 64'h1600, 1'b0, 1'b0, Z, 1'b0);
        look("flushed_1800", 64'h1800, 1'b0, 1'b0, Z, 1'b0);
        look("flushed_1002", 64'h1002, 1'b0, 1'b0, Z, 1'b0);
        look("dropped_1A00", 64'h1A00, 1'b0, 1'b0, Z, 1'b0);

        // After the flush: 0x1000 -> way0, 0x1200 -> way1, 0x1400 evicts way0 (rr cleared)
        br(64'h1000, 1'b1, 64'h2000);
        look("realloc_1000", 64'h1000, 1'b1, 1'b1, 64'h2000, 1'b0);
        br(64'h1200, 1'b0, 64'h2200);
        br(64'h1400, 1'b1, 64'h2400);
        look("rr_clr_1000", 64'h1000, 1'b0, 1'b0, Z, 1'b0);
        look("rr_clr_1200", 64'h1200, 1'b1, 1'b0, 64'h2200, 1'b0);

        // Asynchronous reset during a pending write: write lost, table empty
        set_br(64'h1000, 1'b1, 64'h2000);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        clear_strobes();
        rst_n = 1'b1;
        look("rst_lost_1000", 64'h1000, 1'b0, 1'b0, Z, 1'b0);
        look("rst_clr_1200", 64'h1200, 1'b0, 1'b0, Z, 1'b0);

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
